// File: rtl/led_fader.sv
// Per-LED PWM fade engine: ramps each of 8 LED levels toward the set_i target word.
// Latency: led_o/busy_o are registered, reflecting counter/level state one cycle earlier.
// Backpressure: none; set_i is a level input sampled on brightness-step cycles only.
//
// Ports:
//   wb_clk  - system clock, rising edge
//   wb_rst  - synchronous active-high reset
//   set_i   - target word, bit i = 1 requests LED i fully on
//   led_o   - PWM-modulated LED drive (registered)
//   busy_o  - high while any LED level differs from its target (registered)
//
// Optional feature: define LED_FADER_GAMMA_EN for a squared (gamma) duty mapping.
module led_fader #(
  parameter int unsigned PRESCALE     = 4,   // clock cycles per PWM tick, 1..65535
  parameter int unsigned STEP_PERIODS = 8    // PWM periods per brightness step, 1..255
) (
  input  logic       wb_clk,
  input  logic       wb_rst,
  input  logic [7:0] set_i,
  output logic [7:0] led_o,
  output logic       busy_o
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);
  localparam logic [7:0]  STEP_LAST  = 8'(STEP_PERIODS - 1);

  logic [15:0]     presc_q, presc_d;
  logic [7:0]      pwm_q, pwm_d;
  logic [7:0]      step_cnt_q, step_cnt_d;
  logic [7:0][7:0] level_q, level_d;
  logic [7:0]      led_q, led_d;
  logic            busy_q, busy_d;

  logic            tick;
  logic            period_end;
  logic            step;
  logic [7:0][7:0] duty;

  assign tick       = (presc_q == PRESC_LAST);
  assign period_end = tick && (pwm_q == 8'hFF);
  assign step       = period_end && (step_cnt_q == STEP_LAST);

  // Duty mapping from the current level.
  for (genvar g = 0; g < 8; g++) begin : g_duty
`ifdef LED_FADER_GAMMA_EN
    // Upper byte of the 16-bit square: a perceptually even ramp.
    assign duty[g] = 8'(({8'd0, level_q[g]} * {8'd0, level_q[g]}) >> 8);
`else
    assign duty[g] = level_q[g];
`endif
  end

  always_comb begin
    presc_d    = tick ? 16'd0 : presc_q + 16'd1;
    pwm_d      = tick ? pwm_q + 8'd1 : pwm_q;   // wraps 255 -> 0 naturally
    step_cnt_d = step_cnt_q;
    if (period_end) begin
      step_cnt_d = (step_cnt_q == STEP_LAST) ? 8'd0 : step_cnt_q + 8'd1;
    end

    level_d = level_q;
    led_d   = '0;
    busy_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      // Saturating ramp toward the target; set_i only matters on a step.
      if (step) begin
        if (set_i[i] && (level_q[i] != 8'hFF)) begin
          level_d[i] = level_q[i] + 8'd1;
        end else if (!set_i[i] && (level_q[i] != 8'h00)) begin
          level_d[i] = level_q[i] - 8'd1;
        end
      end
      // Full level is forced solid so the LED never blinks off at pwm 255.
      led_d[i] = (level_q[i] == 8'hFF) || (pwm_q < duty[i]);
      busy_d   = busy_d | (level_q[i] != {8{set_i[i]}});
    end
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      presc_q    <= '0;
      pwm_q      <= '0;
      step_cnt_q <= '0;
      level_q    <= '0;
      led_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      pwm_q      <= pwm_d;
      step_cnt_q <= step_cnt_d;
      level_q    <= level_d;
      led_q      <= led_d;
      busy_q     <= busy_d;
    end
  end

  assign led_o  = led_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_led_fader.sv
module tb_led_fader;

  logic       wb_clk = 1'b0;
  logic       wb_rst = 1'b1;
  logic [7:0] set_i  = 8'hFF;
  logic [7:0] led_o;
  logic       busy_o;

  int checks = 0;
  int errors = 0;

  led_fader #(.PRESCALE(1), .STEP_PERIODS(1)) dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .set_i  (set_i),
    .led_o  (led_o),
    .busy_o (busy_o)
  );

  always #5 wb_clk = ~wb_clk;

  // Expected 256-sample pulse for a given level: high for duty samples
  // starting at pwm 0, or solid at level 255.
  function automatic logic [255:0] exp_vec(input int lvl);
    logic [255:0] v;
    int d;
    v = '0;
    if (lvl >= 255) begin
      v = '1;
    end else begin
`ifdef LED_FADER_GAMMA_EN
      d = (lvl * lvl) >> 8;
`else
      d = lvl;
`endif
      for (int i = 0; i < d; i++) v[i] = 1'b1;
    end
    return v;
  endfunction

  // LED1 goes up with LED0 until level 100, then reverses to 0.
  function automatic int lvl1(input int n);
    if (n <= 100) return n;
    if (n <= 200) return 200 - n;
    return 0;
  endfunction

  // Capture one PWM window of 256 cycles (no comparisons here).
  task automatic measure(output logic [255:0] v0, output logic [255:0] v1,
                         output logic [255:0] vo, output logic b_early,
                         output logic b_mid);
    for (int i = 0; i < 256; i++) begin
      @(negedge wb_clk);
      v0[i] = led_o[0];
      v1[i] = led_o[1];
      vo[i] = |led_o[7:2];
      if (i == 1)   b_early = busy_o;
      if (i == 128) b_mid   = busy_o;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      checks++;
      if (led_o !== 8'h00) begin
        errors++;
        $display("FAIL reset_hold_led cycle %0d got %h want 00", i, led_o);
      end
      checks++;
      if (busy_o !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_busy cycle %0d got %b want 0", i, busy_o);
      end
    end
    wb_rst = 1'b0;
    set_i  = 8'h01;
  endtask

  task automatic test_reset_mid_fade();
    logic [255:0] v0, v1, vo;
    logic be, bm;
    for (int n = 0; n < 50; n++) begin
      measure(v0, v1, vo, be, bm);
      checks++;
      if (v0 !== exp_vec(n)) begin
        errors++;
        $display("FAIL pre_rst_led0 win %0d got %h want %h", n, v0, exp_vec(n));
      end
      checks++;
      if ((v1 | vo) !== '0) begin
        errors++;
        $display("FAIL pre_rst_others win %0d got %h/%h want 0", n, v1, vo);
      end
      checks++;
      if (bm !== 1'b1) begin
        errors++;
        $display("FAIL pre_rst_busy win %0d got %b want 1", n, bm);
      end
      if (n == 0) begin
        checks++;
        if (be !== 1'b1) begin
          errors++;
          $display("FAIL busy_after_release got %b want 1", be);
        end
      end
    end
    // Level is 50 here; pulse reset for one cycle mid-period.
    repeat (10) @(negedge wb_clk);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    checks++;
    if (led_o !== 8'h00) begin
      errors++;
      $display("FAIL mid_rst_led got %h want 00", led_o);
    end
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst_busy got %b want 0", busy_o);
    end
    wb_rst = 1'b0;
    set_i  = 8'h03;
    // Level restarts from 0; first step lands 256 cycles after release.
    for (int n = 0; n < 2; n++) begin
      measure(v0, v1, vo, be, bm);
      checks++;
      if (v0 !== exp_vec(n)) begin
        errors++;
        $display("FAIL restart_led0 win %0d got %h want %h", n, v0, exp_vec(n));
      end
      checks++;
      if (v1 !== exp_vec(n)) begin
        errors++;
        $display("FAIL restart_led1 win %0d got %h want %h", n, v1, exp_vec(n));
      end
      if (n == 0) begin
        checks++;
        if (be !== 1'b1) begin
          errors++;
          $display("FAIL restart_busy got %b want 1", be);
        end
      end
    end
  endtask

  task automatic test_fade_and_reversal();
    logic [255:0] v0, v1, vo;
    logic be, bm;
    for (int n = 2; n <= 256; n++) begin
      if (n == 100) set_i = 8'h01;   // reverse LED1 while at level 100
      measure(v0, v1, vo, be, bm);
      checks++;
      if (v0 !== exp_vec(n)) begin
        errors++;
        $display("FAIL fade_led0 win %0d got %h want %h", n, v0, exp_vec(n));
      end
      checks++;
      if (v1 !== exp_vec(lvl1(n))) begin
        errors++;
        $display("FAIL fade_led1 win %0d got %h want %h", n, v1, exp_vec(lvl1(n)));
      end
      checks++;
      if (vo !== '0) begin
        errors++;
        $display("FAIL fade_led_hi win %0d got %h want 0", n, vo);
      end
      checks++;
      if (bm !== (n < 255)) begin
        errors++;
        $display("FAIL fade_busy win %0d got %b want %b", n, bm, (n < 255));
      end
`ifdef LED_FADER_GAMMA_EN
      if (n == 128) begin
        checks++;
        if ($countones(v0) != 64) begin
          errors++;
          $display("FAIL gamma_duty128 got %0d want 64", $countones(v0));
        end
      end
`else
      if (n == 64) begin
        checks++;
        if ($countones(v0) != 64) begin
          errors++;
          $display("FAIL linear_duty64 got %0d want 64", $countones(v0));
        end
      end
`endif
    end
  endtask

  task automatic test_busy_latency();
    // LED0 idle-on, LED1 idle-off, set_i = 0x01.
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_busy got %b want 0", busy_o);
    end
    set_i = 8'h00;
    @(negedge wb_clk);
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("FAIL busy_rise got %b want 1", busy_o);
    end
    set_i = 8'h01;
    @(negedge wb_clk);
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL busy_fall got %b want 0", busy_o);
    end
    checks++;
    if (led_o !== 8'h01) begin
      errors++;
      $display("FAIL no_step_led got %h want 01", led_o);
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_fade();
    test_fade_and_reversal();
    test_busy_latency();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
